// File: rtl/oam_dma_engine.sv
// Sprite-DMA controller: a write to TRIG_ADDR halts the CPU and copies XFER_LEN bytes
// from the selected page to DEST_ADDR. Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN slot.
module oam_dma_engine #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
  parameter logic [ADDR_W-1:0] DEST_ADDR = 16'h2004,
  parameter int                XFER_LEN  = 256
) (
  input  logic              cpu_clk,
  input  logic              res_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_r_w_n,
  input  logic [DATA_W-1:0] bus_din,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              cycle_odd,
  output logic              dma_hijack,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_r_w_n,
  output logic [DATA_W-1:0] dma_dout,
  output logic              dma_done
);

  localparam int IDX_W = $clog2(XFER_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        page_q, page_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hijack_q, hijack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              r_w_n_q, r_w_n_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              trig;
  logic [7:0]        idx_lo;

`ifndef OAM_DMA_ALIGN_EN
  logic unused_cycle_odd;
  assign unused_cycle_odd = cycle_odd;
`endif

  assign trig = !bus_r_w_n && (bus_addr == TRIG_ADDR);

  always_ff @(posedge cpu_clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= S_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      hijack_q <= 1'b0;
      addr_q   <= '0;
      r_w_n_q  <= 1'b1;
      dout_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      hijack_q <= hijack_d;
      addr_q   <= addr_d;
      r_w_n_q  <= r_w_n_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          page_d  = bus_din[7:0];
          idx_d   = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = cycle_odd ? S_ALIGN : S_READ;
`else
        state_d = S_READ;
`endif
      end
      S_ALIGN: state_d = S_READ;
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q
  // without any input-to-output combinational path.
  always_comb begin
    idx_lo   = 8'(idx_d);
    hijack_d = state_d inside {S_HALT, S_ALIGN, S_READ, S_WRITE};
    addr_d   = '0;
    r_w_n_d  = 1'b1;
    done_d   = (state_d == S_DONE);
    case (state_d)
      S_READ:  addr_d = ADDR_W'({page_d, idx_lo});
      S_WRITE: begin
        addr_d  = DEST_ADDR;
        r_w_n_d = 1'b0;
      end
      default: ;
    endcase
    if (state_q == S_READ) begin
      dout_d = bus_rdata;
    end else if (hijack_d) begin
      dout_d = dout_q;
    end else begin
      dout_d = '0;
    end
  end

  assign dma_hijack = hijack_q;
  assign dma_addr   = addr_q;
  assign dma_r_w_n  = r_w_n_q;
  assign dma_dout   = dout_q;
  assign dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Self-checking bench for oam_dma_engine: a default 256-byte instance and a 4-byte instance,
// each reading from a shared behavioural memory, checked against transfer expectations.
module tb_oam_dma_engine;

  localparam int LEN0 = 256;
  localparam int LEN1 = 4;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
`ifdef OAM_DMA_ALIGN_EN
  localparam int ALIGN_ON = 1;
`else
  localparam int ALIGN_ON = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n;
  logic        odd;
  logic [7:0]  mem [0:65535];

  logic [15:0] a_addr [2];
  logic        a_rwn  [2];
  logic [7:0]  a_din  [2];
  logic        h0, h1, rw0, rw1, dn0, dn1;
  logic [15:0] ad0, ad1;
  logic [7:0]  do0, do1, rd0, rd1;

  assign rd0 = mem[ad0];
  assign rd1 = mem[ad1];

  oam_dma_engine dut0 (
    .cpu_clk(clk), .res_n(res_n), .bus_addr(a_addr[0]), .bus_r_w_n(a_rwn[0]),
    .bus_din(a_din[0]), .bus_rdata(rd0), .cycle_odd(odd), .dma_hijack(h0),
    .dma_addr(ad0), .dma_r_w_n(rw0), .dma_dout(do0), .dma_done(dn0)
  );

  oam_dma_engine #(.XFER_LEN(LEN1)) dut1 (
    .cpu_clk(clk), .res_n(res_n), .bus_addr(a_addr[1]), .bus_r_w_n(a_rwn[1]),
    .bus_din(a_din[1]), .bus_rdata(rd1), .cycle_odd(odd), .dma_hijack(h1),
    .dma_addr(ad1), .dma_r_w_n(rw1), .dma_dout(do1), .dma_done(dn1)
  );

  int checks = 0;
  int failures = 0;

  // Bus monitor: classifies every cycle of each instance.
  int          hij_cnt [2];
  int          nop_cnt [2];
  int          done_cnt[2];
  int          wr_cnt  [2];
  int          rd_cnt  [2];
  int          viol    [2];
  logic [15:0] wr_addr [2][0:511];
  logic [7:0]  wr_data [2][0:511];
  logic [15:0] rd_addr [2][0:511];

  task automatic mon(input int k, input logic h, input logic [15:0] a, input logic rw,
                     input logic [7:0] d, input logic dn);
    if (dn) done_cnt[k]++;
    if (dn && h) viol[k]++;
    if (h) begin
      hij_cnt[k]++;
      if (rw === 1'b0) begin
        if (wr_cnt[k] < 512) begin
          wr_addr[k][wr_cnt[k]] = a;
          wr_data[k][wr_cnt[k]] = d;
        end
        wr_cnt[k]++;
      end else if (a != 16'h0) begin
        if (rd_cnt[k] < 512) rd_addr[k][rd_cnt[k]] = a;
        rd_cnt[k]++;
      end else begin
        nop_cnt[k]++;
      end
    end else if (a !== 16'h0 || rw !== 1'b1 || d !== 8'h0) begin
      viol[k]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, h0, ad0, rw0, do0, dn0);
    mon(1, h1, ad1, rw1, do1, dn1);
  end

  task automatic clear(input int k);
    hij_cnt[k] = 0; nop_cnt[k] = 0; done_cnt[k] = 0;
    wr_cnt[k] = 0; rd_cnt[k] = 0; viol[k] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input int k, input logic [15:0] a, input logic rw, input logic [7:0] d);
    a_addr[k] = a;
    a_rwn[k]  = rw;
    a_din[k]  = d;
  endtask

  task automatic drive_idle(input int k);
    logic [15:0] a;
    a = 16'($urandom);
    if (a == TRIG) a = 16'h0000;
    drive(k, a, 1'($urandom), 8'($urandom));
  endtask

  task automatic wait_done(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (done_cnt[k] != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    odd = 1'b0;
    drive(0, TRIG, 1'b0, 8'h02);
    drive(1, TRIG, 1'b0, 8'h07);
    step();
    step();
    checks++;
    if ({h0, ad0, rw0, do0, dn0} !== {1'b0, 16'h0, 1'b1, 8'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_dut0: got h=%b a=%h rw=%b d=%h dn=%b want 0 0000 1 00 0",
               h0, ad0, rw0, do0, dn0);
    end
    checks++;
    if ({h1, ad1, rw1, do1, dn1} !== {1'b0, 16'h0, 1'b1, 8'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_dut1: got h=%b a=%h rw=%b d=%h dn=%b want 0 0000 1 00 0",
               h1, ad1, rw1, do1, dn1);
    end
    drive_idle(0);
    drive_idle(1);
    res_n = 1'b1;
    step();
    step();
    checks++;
    if (h0 !== 1'b0 || h1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got hijack %b/%b want 0/0", h0, h1);
    end
  endtask

  task automatic test_transfer(input int k, input logic [7:0] page, input logic odd_v);
    int  len, exp_hij, bad, first_bad;
    bit  ok;
    logic [15:0] exp_src;
    len = (k == 0) ? LEN0 : LEN1;
    exp_hij = 1 + 2 * len + ((ALIGN_ON != 0 && odd_v) ? 1 : 0);
    step();
    clear(k);
    odd = odd_v;
    drive(k, TRIG, 1'b0, page);
    step();
    checks++;
    if (((k == 0) ? h0 : h1) !== 1'b1) begin
      failures++;
      $display("FAIL xfer_hijack_rise[%0d]: got 0 want 1", k);
    end
    drive_idle(k);
    wait_done(k, 2000, ok);
    step();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL xfer_timeout[%0d] page=%h: got no dma_done want one", k, page);
    end
    checks++;
    if (hij_cnt[k] != exp_hij) begin
      failures++;
      $display("FAIL xfer_hijack_len[%0d] page=%h odd=%b: got %0d want %0d", k, page, odd_v,
               hij_cnt[k], exp_hij);
    end
    checks++;
    if (nop_cnt[k] != exp_hij - 2 * len) begin
      failures++;
      $display("FAIL xfer_idle_cycles[%0d]: got %0d want %0d", k, nop_cnt[k], exp_hij - 2 * len);
    end
    checks++;
    if (wr_cnt[k] != len || rd_cnt[k] != len) begin
      failures++;
      $display("FAIL xfer_access_count[%0d]: got w=%0d r=%0d want %0d", k, wr_cnt[k],
               rd_cnt[k], len);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < len && i < wr_cnt[k] && i < rd_cnt[k]; i++) begin
      exp_src = {page, 8'(i)};
      if (wr_addr[k][i] !== DEST || wr_data[k][i] !== mem[exp_src] || rd_addr[k][i] !== exp_src) begin
        if (first_bad < 0) first_bad = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL xfer_data[%0d] page=%h: %0d bad bytes, first idx %0d got r=%h w=%h d=%h want r=%h w=%h d=%h",
               k, page, bad, first_bad, rd_addr[k][first_bad], wr_addr[k][first_bad],
               wr_data[k][first_bad], {page, 8'(first_bad)}, DEST, mem[{page, 8'(first_bad)}]);
    end
    checks++;
    if (done_cnt[k] != 1 || viol[k] != 0) begin
      failures++;
      $display("FAIL xfer_done_protocol[%0d]: got done=%0d viol=%0d want 1 0", k, done_cnt[k],
               viol[k]);
    end
  endtask

  task automatic test_bad_trigger();
    step();
    clear(0);
    drive(0, TRIG, 1'b1, 8'h02);
    step();
    drive(0, TRIG + 16'h1, 1'b0, 8'h02);
    step();
    for (int n = 0; n < 6; n++) begin
      drive_idle(0);
      step();
    end
    checks++;
    if (hij_cnt[0] != 0 || wr_cnt[0] != 0 || rd_cnt[0] != 0 || done_cnt[0] != 0 || viol[0] != 0) begin
      failures++;
      $display("FAIL bad_trigger: got hij=%0d w=%0d r=%0d done=%0d viol=%0d want all 0",
               hij_cnt[0], wr_cnt[0], rd_cnt[0], done_cnt[0], viol[0]);
    end
  endtask

  task automatic test_reset_midway();
    bit ok;
    step();
    clear(0);
    odd = 1'b0;
    drive(0, TRIG, 1'b0, 8'h02);
    step();
    drive_idle(0);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (wr_cnt[0] >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midreset_reach: got %0d writes want 10", wr_cnt[0]);
    end
    #1 res_n = 1'b0;
    #1;
    checks++;
    if ({h0, ad0, rw0, do0, dn0} !== {1'b0, 16'h0, 1'b1, 8'h0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_async: got h=%b a=%h rw=%b d=%h dn=%b want 0 0000 1 00 0",
               h0, ad0, rw0, do0, dn0);
    end
    step();
    res_n = 1'b1;
    clear(0);
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (hij_cnt[0] != 0 || wr_cnt[0] != 0 || done_cnt[0] != 0) begin
      failures++;
      $display("FAIL midreset_no_resume: got hij=%0d w=%0d done=%0d want 0 0 0", hij_cnt[0],
               wr_cnt[0], done_cnt[0]);
    end
  endtask

  task automatic test_done_retrigger(input logic [7:0] p1, input logic [7:0] p2);
    bit ok;
    int bad;
    step();
    odd = 1'b0;
    drive(0, TRIG, 1'b0, p1);
    step();
    drive_idle(0);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      step();
      if (dn0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL retrig_first_done: got no dma_done want one");
    end
    drive(0, TRIG, 1'b0, p2);
    step();
    checks++;
    if (h0 !== 1'b0) begin
      failures++;
      $display("FAIL retrig_in_done_ignored: got hijack %b want 0", h0);
    end
    clear(0);
    step();
    checks++;
    if (h0 !== 1'b1) begin
      failures++;
      $display("FAIL retrig_next_starts: got hijack %b want 1", h0);
    end
    drive_idle(0);
    wait_done(0, 2000, ok);
    step();
    bad = 0;
    for (int i = 0; i < LEN0 && i < wr_cnt[0]; i++)
      if (wr_data[0][i] !== mem[{p2, 8'(i)}]) bad++;
    checks++;
    if (!ok || hij_cnt[0] != 1 + 2 * LEN0 || wr_cnt[0] != LEN0 || bad != 0 || done_cnt[0] != 1) begin
      failures++;
      $display("FAIL retrig_second_xfer: got ok=%0d hij=%0d w=%0d bad=%0d done=%0d want 1 %0d %0d 0 1",
               ok, hij_cnt[0], wr_cnt[0], bad, done_cnt[0], 1 + 2 * LEN0, LEN0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p, q;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    drive_idle(0);
    drive_idle(1);

    test_reset();
    test_transfer(0, 8'h02, 1'b0);
    test_transfer(0, 8'h02, 1'b1);
    test_bad_trigger();
    test_reset_midway();
    test_transfer(0, 8'h02, 1'b0);
    test_transfer(1, 8'h07, 1'b0);
    for (int n = 0; n < 3; n++) begin
      p = 8'($urandom_range(1, 255));
      test_transfer(0, p, 1'($urandom));
      test_transfer(1, p, 1'($urandom));
    end
    p = 8'($urandom_range(1, 127));
    q = 8'($urandom_range(128, 255));
    test_done_retrigger(p, q);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
